// File: rtl/fetch_sequencer.sv
// Instruction fetch/retire sequencer: IDLE -> FETCH -> WAIT -> EXEC, with a sticky FAULT state.
// Optional retirement counter enabled by defining FETCH_SEQUENCER_PERF_CNT_EN.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        halt_req_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] instr_o,
  output logic        instr_valid_o,
  input  logic        exec_done_i,
  input  logic [1:0]  pc_src_i,
  input  logic [31:0] imm_i,
  input  logic [31:0] pc_from_ju_i,
  output logic [31:0] pc_o,
  output logic        fault_o,
  output logic        busy_o
`ifdef FETCH_SEQUENCER_PERF_CNT_EN
  ,
  output logic [31:0] retired_cnt_o
`endif
);

  localparam logic [7:0] WaitMaxC = 8'(WAIT_MAX);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StFetch = 3'd1,
    StWait  = 3'd2,
    StExec  = 3'd3,
    StFault = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        halt_q, halt_d;

  logic [31:0] next_pc;
  logic        misaligned;
  logic [7:0]  wait_cnt_inc;
  logic        retire;

  // Carry out of the adders is dropped, so the PC wraps modulo 2^32.
  always_comb begin
    next_pc = pc_q + 32'd4;
    if (pc_src_i == 2'b11) begin
      next_pc = pc_from_ju_i;
    end else if (pc_src_i == 2'b01) begin
      next_pc = pc_q + imm_i;
    end
  end

  assign misaligned   = |next_pc[1:0];
  assign wait_cnt_inc = wait_cnt_q + 8'd1;
  assign retire       = (state_q == StExec) && exec_done_i && !misaligned;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    wait_cnt_d = wait_cnt_q;
    halt_d     = halt_q;

    unique case (state_q)
      StIdle: begin
        // A halt request seen here is dropped; start still wins.
        halt_d = 1'b0;
        if (start_i) begin
          state_d = StFetch;
        end
      end

      StFetch: begin
        wait_cnt_d = '0;
        halt_d     = halt_q | halt_req_i;
        state_d    = StWait;
      end

      StWait: begin
        halt_d = halt_q | halt_req_i;
        if (imem_ready_i) begin
          instr_d = imem_rdata_i;
          state_d = StExec;
        end else begin
          wait_cnt_d = wait_cnt_inc;
          if (wait_cnt_inc == WaitMaxC) begin
            state_d = StFault;
          end
        end
      end

      StExec: begin
        halt_d = halt_q | halt_req_i;
        if (exec_done_i) begin
          if (misaligned) begin
            state_d = StFault;
          end else begin
            pc_d    = next_pc;
            halt_d  = 1'b0;
            state_d = (halt_req_i || halt_q) ? StIdle : StFetch;
          end
        end
      end

      StFault: begin
        state_d = StFault;
      end

      default: begin
        state_d = StFault;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      wait_cnt_q <= '0;
      halt_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      wait_cnt_q <= wait_cnt_d;
      halt_q     <= halt_d;
    end
  end

  always_comb begin
    imem_req_o    = (state_q == StFetch);
    imem_addr_o   = pc_q;
    instr_o       = instr_q;
    instr_valid_o = (state_q == StExec);
    pc_o          = pc_q;
    fault_o       = (state_q == StFault);
    busy_o        = (state_q != StIdle) && (state_q != StFault);
  end

`ifdef FETCH_SEQUENCER_PERF_CNT_EN
  logic [31:0] retired_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      retired_cnt_q <= '0;
    end else if (retire) begin
      retired_cnt_q <= retired_cnt_q + 32'd1;
    end
  end

  assign retired_cnt_o = retired_cnt_q;
`else
  logic unused_retire;
  assign unused_retire = retire;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer (WAIT_MAX=3, RESET_PC=0).
module tb_fetch_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic        halt_req_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ready_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] instr_o;
  logic        instr_valid_o;
  logic        exec_done_i;
  logic [1:0]  pc_src_i;
  logic [31:0] imm_i;
  logic [31:0] pc_from_ju_i;
  logic [31:0] pc_o;
  logic        fault_o;
  logic        busy_o;
`ifdef FETCH_SEQUENCER_PERF_CNT_EN
  logic [31:0] retired_cnt_o;
`endif

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  fetch_sequencer #(
    .RESET_PC(32'h0000_0000),
    .WAIT_MAX(3)
  ) u_dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .halt_req_i   (halt_req_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_ready_i (imem_ready_i),
    .imem_rdata_i (imem_rdata_i),
    .instr_o      (instr_o),
    .instr_valid_o(instr_valid_o),
    .exec_done_i  (exec_done_i),
    .pc_src_i     (pc_src_i),
    .imm_i        (imm_i),
    .pc_from_ju_i (pc_from_ju_i),
    .pc_o         (pc_o),
    .fault_o      (fault_o),
    .busy_o       (busy_o)
`ifdef FETCH_SEQUENCER_PERF_CNT_EN
    ,
    .retired_cnt_o(retired_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(negedge clk_i);
  endtask

  // Entered in FETCH; leaves the DUT in EXEC holding word.
  task automatic fetch_instr(input logic [31:0] word);
    step();
    imem_ready_i = 1'b1;
    imem_rdata_i = word;
    step();
    imem_ready_i = 1'b0;
    imem_rdata_i = '0;
  endtask

  task automatic retire(input logic [1:0] src, input logic [31:0] im, input logic [31:0] ju);
    exec_done_i  = 1'b1;
    pc_src_i     = src;
    imm_i        = im;
    pc_from_ju_i = ju;
    step();
    exec_done_i  = 1'b0;
    pc_src_i     = 2'b00;
    imm_i        = '0;
    pc_from_ju_i = '0;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; start_i = 1'b0; halt_req_i = 1'b0; imem_ready_i = 1'b0;
    imem_rdata_i = '0; exec_done_i = 1'b0; pc_src_i = 2'b00; imm_i = '0; pc_from_ju_i = '0;
    step();
    step();
    rst_i = 1'b0;
    check("rst_pc", pc_o, 32'h0);
    check("rst_instr", instr_o, 32'h0);
    check("rst_valid", instr_valid_o, 0);
    check("rst_req", imem_req_o, 0);
    check("rst_fault", fault_o, 0);
    check("rst_busy", busy_o, 0);

    // Basic fetch/execute of one instruction
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    check("fetch_req", imem_req_o, 1);
    check("fetch_addr", imem_addr_o, 32'h0);
    check("fetch_busy", busy_o, 1);
    step();
    check("wait_req_low", imem_req_o, 0);
    imem_ready_i = 1'b1; imem_rdata_i = 32'h0000_0013;
    step();
    imem_ready_i = 1'b0; imem_rdata_i = '0;
    check("exec_instr", instr_o, 32'h13);
    check("exec_valid", instr_valid_o, 1);
    // Ready outside WAIT is ignored
    imem_ready_i = 1'b1; imem_rdata_i = 32'hDEAD_BEEF;
    step();
    imem_ready_i = 1'b0; imem_rdata_i = '0;
    check("ready_ignored", instr_o, 32'h13);
    retire(2'b00, 32'h0, 32'h0);
    check("seq_pc", pc_o, 32'h4);
    check("retire_latency_req", imem_req_o, 1);

    // PC select paths
    fetch_instr(32'h13);
    retire(2'b00, 32'h0, 32'h0);
    check("pc_8", pc_o, 32'h8);
    fetch_instr(32'h13);
    retire(2'b01, 32'hFFFF_FFF8, 32'h0);
    check("branch_back", pc_o, 32'h0);
    fetch_instr(32'h13);
    retire(2'b11, 32'h0, 32'h100);
    check("jump_100", pc_o, 32'h100);
    fetch_instr(32'h13);
    retire(2'b10, 32'h0, 32'hFFFF_FFFC);
    check("src10_seq", pc_o, 32'h104);
    fetch_instr(32'h13);
    retire(2'b11, 32'h0, 32'hFFFF_FFFC);
    check("jump_top", pc_o, 32'hFFFF_FFFC);
    fetch_instr(32'h13);
    retire(2'b00, 32'h0, 32'h0);
    check("pc_wrap", pc_o, 32'h0);

    // Misaligned target faults and keeps the old PC
    fetch_instr(32'h13);
    retire(2'b11, 32'h0, 32'h102);
    check("mis_fault", fault_o, 1);
    check("mis_pc", pc_o, 32'h0);
    check("mis_busy", busy_o, 0);
    check("mis_valid", instr_valid_o, 0);
    start_i = 1'b1; imem_ready_i = 1'b1;
    repeat (3) step();
    start_i = 1'b0; imem_ready_i = 1'b0;
    check("fault_sticky", fault_o, 1);
    check("fault_no_req", imem_req_o, 0);
    do_reset();
    check("fault_cleared", fault_o, 0);
    check("fault_rst_busy", busy_o, 0);

    // WAIT timeout after WAIT_MAX=3 cycles
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    repeat (3) step();
    check("wait3_not_fault", fault_o, 0);
    check("wait3_busy", busy_o, 1);
    step();
    check("timeout_fault", fault_o, 1);
    imem_ready_i = 1'b1;
    repeat (2) step();
    imem_ready_i = 1'b0;
    check("timeout_sticky", fault_o, 1);
    do_reset();

    // Ready on the last allowed WAIT cycle is accepted
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    repeat (3) step();
    imem_ready_i = 1'b1; imem_rdata_i = 32'h0000_0033;
    step();
    imem_ready_i = 1'b0; imem_rdata_i = '0;
    check("late_ready_valid", instr_valid_o, 1);
    check("late_ready_instr", instr_o, 32'h33);
    check("late_ready_nofault", fault_o, 0);
    retire(2'b00, 32'h0, 32'h0);

    // Halt pulsed during WAIT
    step();
    halt_req_i = 1'b1;
    step();
    halt_req_i = 1'b0;
    imem_ready_i = 1'b1; imem_rdata_i = 32'h0000_0044;
    step();
    imem_ready_i = 1'b0; imem_rdata_i = '0;
    check("halt_instr", instr_o, 32'h44);
    retire(2'b00, 32'h0, 32'h0);
    check("halt_pc", pc_o, 32'h8);
    check("halt_busy", busy_o, 0);
    check("halt_req", imem_req_o, 0);
    step();
    check("halt_stay_idle", busy_o, 0);

    // Start with halt in IDLE: halt not latched
    start_i = 1'b1; halt_req_i = 1'b1;
    step();
    start_i = 1'b0; halt_req_i = 1'b0;
    check("start_halt_fetch", imem_req_o, 1);
    fetch_instr(32'h13);
    retire(2'b00, 32'h0, 32'h0);
    check("no_halt_latch", imem_req_o, 1);
    check("no_halt_pc", pc_o, 32'hC);

    // Halt in the same cycle as exec_done
    fetch_instr(32'h13);
    halt_req_i = 1'b1;
    retire(2'b00, 32'h0, 32'h0);
    halt_req_i = 1'b0;
    check("halt_same_busy", busy_o, 0);
    check("halt_same_pc", pc_o, 32'h10);

    // Reset mid-WAIT with ready in the same cycle
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    step();
    rst_i = 1'b1; imem_ready_i = 1'b1; imem_rdata_i = 32'h0000_0055;
    step();
    rst_i = 1'b0; imem_ready_i = 1'b0; imem_rdata_i = '0;
    check("rstwait_pc", pc_o, 32'h0);
    check("rstwait_instr", instr_o, 32'h0);
    check("rstwait_valid", instr_valid_o, 0);
    check("rstwait_busy", busy_o, 0);
    step();
    check("rstwait_idle", busy_o, 0);

`ifdef FETCH_SEQUENCER_PERF_CNT_EN
    check("cnt_rst", retired_cnt_o, 32'd0);
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      fetch_instr(32'h13);
      retire(2'b00, 32'h0, 32'h0);
    end
    check("cnt_5", retired_cnt_o, 32'd5);
    fetch_instr(32'h13);
    retire(2'b11, 32'h0, 32'h102);
    check("cnt_no_fault_inc", retired_cnt_o, 32'd5);
    do_reset();
    check("cnt_cleared", retired_cnt_o, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 SHALL have parameter WAIT_MAX, default 15: max cycles spent in WAIT before fault (range 1..255).
REQ-003 SHALL use one clock and a synchronous, active-high reset.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 start  in  1  leave IDLE and begin fetching.
REQ-007 halt_req  in  1  return to IDLE after current instruction retires.
REQ-008 imem_req  out  1  instruction-memory read request strobe.
REQ-009 imem_addr  out  32  read address; always equals pc.
REQ-010 imem_ready  in  1  read data valid this cycle.
REQ-011 imem_rdata  in  32  instruction word.
REQ-012 instr  out  32  latched instruction for decode/execute.
REQ-013 instr_valid  out  1  instr valid; high for whole of EXEC.
REQ-014 exec_done  in  1  datapath finished current instruction.
REQ-015 pc_src  in  2  next-PC select: 2'b11 jump/upper-imm target, 2'b01 taken branch, other sequential.
REQ-016 imm  in  32  branch offset.
REQ-017 pc_fromJU  in  32  jump/upper-imm next-PC target.
REQ-018 pc  out  32  current program counter.
REQ-019 fault  out  1  sticky error flag.
REQ-020 busy  out  1  high in every state except IDLE and FAULT.

Function
REQ-021 SHALL implement states IDLE, FETCH, WAIT, EXEC, FAULT, encoded in 3 bits.
REQ-022 IDLE: start=1 -> FETCH next edge; else hold.
REQ-023 FETCH: imem_req=1 for exactly one cycle; wait counter cleared; -> WAIT.
REQ-024 WAIT: imem_ready sampled only here; ready=1 -> instr<=imem_rdata, -> EXEC.
REQ-025 WAIT: counter increments each cycle without ready; reaching WAIT_MAX with no ready -> FAULT.
REQ-026 imem_ready in any state other than WAIT SHALL be ignored.
REQ-027 EXEC: exec_done=1 -> pc<=next_pc; -> FETCH, or -> IDLE when halt_req=1 in same cycle or latched earlier during the instruction.
REQ-028 next_pc: pc_src=2'b11 -> pc_fromJU; 2'b01 -> pc+imm; else pc+4; 32-bit modulo, carry discarded (32'hFFFF_FFFC+4 = 0).
REQ-029 next_pc[1:0]!=0 at exec_done -> pc unchanged, -> FAULT.
REQ-030 halt_req asserted in FETCH/WAIT/EXEC SHALL be latched and honoured at next retirement; in IDLE it is ignored.
REQ-031 start and halt_req both high in IDLE -> FETCH; halt not latched.
REQ-032 FAULT: fault=1, imem_req=0, instr_valid=0; exits only via rst.
REQ-033 Retire-to-next-request latency SHALL be exactly one cycle (EXEC exit edge -> imem_req high).

Reset
REQ-034 On rst: state=IDLE, pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, fault=0, busy=0, wait counter=0, halt latch=0.
REQ-035 rst in any state, including mid-WAIT, SHALL take priority; an imem_ready in the reset cycle is discarded.

Configuration
REQ-036 Macro FETCH_SEQUENCER_PERF_CNT_EN: when defined, adds output retired_cnt (32) incremented on each EXEC retirement (not on misalignment fault), cleared by rst, wrapping at 2^32.
REQ-037 Without the macro, the port and counter SHALL be absent; all other behaviour identical.

Verification
REQ-038 rst, start, ready on first WAIT cycle with rdata=32'h0000_0013, exec_done with pc_src=00 -> instr=32'h13, pc 0 -> 4, next imem_req one cycle after retire.
REQ-039 pc=8, pc_src=01, imm=32'hFFFF_FFF8, exec_done -> pc=0; pc_src=11, pc_fromJU=32'h100 -> pc=32'h100.
REQ-040 WAIT_MAX=3, imem_ready held 0 -> FAULT after 3 WAIT cycles, fault=1 sticky until rst.
REQ-041 pc_src=11, pc_fromJU=32'h102 at exec_done -> FAULT, pc retains old value.
REQ-042 halt_req pulsed during WAIT -> instruction completes, pc updated, state IDLE, busy=0; rst during WAIT with ready same cycle -> pc=RESET_PC, instr=0.
REQ-043 With FETCH_SEQUENCER_PERF_CNT_EN, five retirements -> retired_cnt=5; rst -> 0.
